peripheral_burst_master_wb: RTL and testbench
=============================================

# peripheral_burst_master_wb

Synthesizable Wishbone B3 burst master that turns a single command (start address, beat count, direction, wrap mode) into one Wishbone incrementing or wrapping burst cycle. It sits directly upstream of a Wishbone memory slave (the memory BFM in benches, real RAM/peripherals in the SoC). Write data is streamed in through a valid/ready port and read data is streamed out. It reports completion and bus errors to its client.

## Interface
- `DW`, 32, data width (multiple of 8)
- `AW`, 32, address width
- `MAX_LEN`, 16, maximum beats per command; `LW = $clog2(MAX_LEN+1)` is local
- `RETRY_MAX`, 3, consecutive `wb_rty_i` responses tolerated on one beat before the command is errored

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `wb_clk_i` in 1 — clock
- `wb_rst_ni` in 1 — asynchronous active-low reset
- `cmd_valid_i` in 1 / `cmd_ready_o` out 1 — command handshake
- `cmd_we_i` in 1 — 1 = write burst
- `cmd_adr_i` in AW — byte start address; low `$clog2(DW/8)` bits are forced to 0
- `cmd_len_i` in LW — beats, legal range 1..MAX_LEN
- `cmd_bte_i` in 2 — 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
- `cmd_sel_i` in DW/8 — byte lanes, constant for the whole burst
- `wdat_valid_i` in 1 / `wdat_ready_o` out 1 / `wdat_i` in DW — write data stream
- `rdat_valid_o` out 1 / `rdat_o` out DW / `rdat_last_o` out 1 — read data stream, no backpressure
- `done_o` out 1 — one-cycle completion pulse
- `err_o` out 1 — valid with `done_o`
- Wishbone master outputs: `wb_adr_o` AW, `wb_dat_o` DW, `wb_sel_o` DW/8, `wb_we_o` 1, `wb_bte_o` 2, `wb_cti_o` 3, `wb_cyc_o` 1, `wb_stb_o` 1
- Wishbone master inputs: `wb_dat_i` DW, `wb_ack_i` 1, `wb_err_i` 1, `wb_rty_i` 1

## Operation
- FSM states: IDLE, LOAD, BUS, RETRY, DONE.
- **IDLE**
  - `cmd_ready_o`=1.
  - On accept, latch all command fields.
  - If `cmd_len_i`==0 or `cmd_len_i`>MAX_LEN: go to DONE with error; no bus cycle is issued.
  - Otherwise: write goes to LOAD, read goes to BUS.
- **LOAD**
  - `wb_cyc_o`=1 (held once the burst has started), `wb_stb_o`=0, `wdat_ready_o`=1.
  - On accept, register the data into `wb_dat_o` and go to BUS.
- **BUS**
  - `wb_cyc_o`=`wb_stb_o`=1.
  - `wb_cti_o`=010 on every beat except the last, which uses 111.
  - Response priority is `err` > `ack` > `rty`.
- **ack**
  - Beat counter increments.
  - `wb_adr_o` advances: `next = (adr & ~m) | ((adr + DW/8) & m)`, where `m` = wrap beats·DW/8−1 (all ones for linear).
  - Read: capture `wb_dat_i`.
  - Write, not last beat: `wdat_ready_o`=`wb_ack_i`, so the next word can be accepted in the same cycle for zero-gap bursts. If `wdat_valid_i`=0, go to LOAD.
  - Last beat: go to DONE.
- **err**: abandon the remaining beats and go to DONE with error.
- **rty**
  - Go to RETRY: `cyc`/`stb` low for exactly one cycle, then reissue the same beat, address and data.
  - The retry counter resets on every ack.
  - The (RETRY_MAX+1)-th consecutive rty goes to DONE with error.
- **DONE**: `done_o`=1 and `err_o` as latched; return to IDLE next cycle.
- Reset mid-burst: all state and outputs clear immediately and asynchronously. The partially written memory contents are left as they are.

## Timing
- Reset values:
  - `cmd_ready_o`=1 (IDLE).
  - Every other output is 0, including `wb_cti_o`=000 and `wb_adr_o`=0.
- Read, zero-wait slave:
  - Command accepted at cycle 0.
  - `cyc`/`stb` high from cycle 1; one beat per cycle.
  - `rdat_valid_o`/`rdat_o` are registered, one cycle after each ack.
  - `rdat_last_o` and `done_o` coincide, one cycle after the final ack.
- Write, zero-wait slave:
  - LOAD occupies cycle 1 (data accepted); `stb` high from cycle 2.
  - Full rate thereafter if `wdat_valid_i` stays high.
  - `done_o` one cycle after the final ack.
- Illegal length: `done_o`/`err_o` one cycle after accept.
- `wb_cyc_o` drops in the DONE cycle.

## Configuration
- `PERIPHERAL_WB_BURST_EN` defined:
  - Registered bursts as above.
  - `wb_bte_o` = latched BTE.
- Not defined:
  - Every beat is a classic cycle: `wb_cti_o`=000, `wb_bte_o`=00.
  - `cyc`/`stb` deassert for one cycle between beats.
  - `cmd_bte_i` is ignored and addressing is linear.

## Structure
- CTI/BTE encodings and the next-address function go in `peripheral_wb_pkg`, reused from the existing definitions.
- FSM state enum and wrap-mask constants are added there.
- One sub-module, `peripheral_adr_gen_wb`, holds the address register, the beat and retry counters and the wrap arithmetic.

## Test plan
- **Read burst:** read, adr 0x100, len 4, BTE 00, memory 0xA0..0xA3 → `wb_adr_o` 0x100/104/108/10C; CTI 010,010,010,111; `rdat_o` A0..A3; `rdat_last_o` on the 4th; `done_o` with `err_o`=0.
- **Wrap4 write:** write, adr 0x38, len 4, BTE 01, data 1..4 → addresses 0x38,0x3C,0x30,0x34; readback returns 3,4,1,2 at 0x30..0x3C.
- **Write data gap:** write len 3 with a 2-cycle `wdat_valid_i` gap after beat 1 → `stb` low 2 cycles while `cyc` stays high; CTI unchanged; all data correct.
- **Bus error:** slave `err` on beat 3 of a 4-beat read → exactly 2 `rdat_valid_o` pulses; `cyc` low next cycle; `done_o`&`err_o`.
- **Illegal length:** `cmd_len_i`=0 and 17 → `done_o`&`err_o` one cycle after accept; `wb_cyc_o` never asserted.
- **Retry and reset:** 3 rty then ack → beat completes at the same address; 4 rty → error; `wb_rst_ni` low mid-burst → `cyc`/`stb`/`cti` 0 immediately and `cmd_ready_o`=1.

Source files
------------

// File: rtl/peripheral_wb_pkg.sv
// peripheral_wb_pkg: Wishbone CTI/BTE encodings, burst FSM states and next-address helpers.
// PERIPHERAL_WB_BURST_EN selects registered bursts; undefined builds issue classic cycles.
package peripheral_wb_pkg;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;
    localparam int unsigned WRAP4_BEATS  = 4;
    localparam int unsigned WRAP8_BEATS  = 8;
    localparam int unsigned WRAP16_BEATS = 16;
`ifdef PERIPHERAL_WB_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, BUS, RETRY, DONE} burst_state_e;

    function automatic logic [63:0] wrap_mask(input logic [1:0] bte, input int unsigned nb);
        return bte == BTE_WRAP4  ? 64'(WRAP4_BEATS * nb - 1) :
               bte == BTE_WRAP8  ? 64'(WRAP8_BEATS * nb - 1) :
               bte == BTE_WRAP16 ? 64'(WRAP16_BEATS * nb - 1) : '1;
    endfunction

    // Bits under the mask advance and wrap; bits above it stay fixed.
    function automatic logic [63:0] next_adr(input logic [63:0] adr, input logic [1:0] bte,
                                             input int unsigned nb);
        logic [63:0] m;
        m = wrap_mask(bte, nb);
        return (adr & ~m) | ((adr + 64'(nb)) & m);
    endfunction
endpackage

// File: rtl/peripheral_adr_gen_wb.sv
// peripheral_adr_gen_wb: burst address register, beat and retry counters with wrap arithmetic.
module peripheral_adr_gen_wb
    import peripheral_wb_pkg::*;
#(
    parameter int          AW = 32,
    parameter int unsigned NB = 4,
    parameter int          LW = 5,
    parameter int          RW = 3
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          load,
    input  logic [AW-1:0] start_adr,
    input  logic [1:0]    bte,
    input  logic          adv,
    input  logic          rty,
    output logic [AW-1:0] adr,
    output logic [LW-1:0] beat,
    output logic [RW-1:0] rty_cnt
);
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            adr     <= '0;
            beat    <= '0;
            rty_cnt <= '0;
        end else if (load) begin
            adr     <= start_adr & ~AW'(NB - 1);
            beat    <= '0;
            rty_cnt <= '0;
        end else if (adv) begin
            adr     <= AW'(next_adr(64'(adr), bte, NB));
            beat    <= beat + 1'b1;
            rty_cnt <= '0;
        end else if (rty) begin
            rty_cnt <= rty_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/peripheral_burst_master_wb.sv
// peripheral_burst_master_wb: one command becomes one Wishbone B3 burst with streamed data.
// PERIPHERAL_WB_BURST_EN enables incrementing/wrapping bursts; otherwise each beat is a classic cycle.
module peripheral_burst_master_wb
    import peripheral_wb_pkg::*;
#(
    parameter int  DW        = 32,
    parameter int  AW        = 32,
    parameter int  MAX_LEN   = 16,
    parameter int  RETRY_MAX = 3,
    localparam int LW        = $clog2(MAX_LEN + 1)
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [LW-1:0]   cmd_len_i,
    input  logic [1:0]      cmd_bte_i,
    input  logic [DW/8-1:0] cmd_sel_i,
    input  logic            wdat_valid_i,
    output logic            wdat_ready_o,
    input  logic [DW-1:0]   wdat_i,
    output logic            rdat_valid_o,
    output logic [DW-1:0]   rdat_o,
    output logic            rdat_last_o,
    output logic            done_o,
    output logic            err_o,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic [1:0]      wb_bte_o,
    output logic [2:0]      wb_cti_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_rty_i
);
    localparam int unsigned NB = DW / 8;
    localparam int          RW = $clog2(RETRY_MAX + 2);

    burst_state_e  state;
    logic [LW-1:0] len_q, beat;
    logic [RW-1:0] rty_cnt;
    logic [1:0]    bte_q;
    logic          load, adv, rty, last, ack_ok, rty_ok, bad_len;

    assign ack_ok       = wb_ack_i && !wb_err_i;
    assign rty_ok       = wb_rty_i && !wb_ack_i && !wb_err_i;
    assign last         = beat == len_q - LW'(1);
    assign bad_len      = cmd_len_i == '0 || cmd_len_i > LW'(MAX_LEN);
    assign load         = state == IDLE && cmd_valid_i;
    assign adv          = state == BUS && ack_ok;
    assign rty          = state == BUS && rty_ok;
    assign wdat_ready_o = state == LOAD || (BURST_EN && adv && wb_we_o && !last);
    assign wb_cti_o     = BURST_EN && wb_stb_o ? (last ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
    assign wb_bte_o     = BURST_EN ? bte_q : BTE_LINEAR;

    peripheral_adr_gen_wb #(.AW(AW), .NB(NB), .LW(LW), .RW(RW)) u_adr_gen (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .load      (load),
        .start_adr (cmd_adr_i),
        .bte       (wb_bte_o),
        .adv       (adv),
        .rty       (rty),
        .adr       (wb_adr_o),
        .beat      (beat),
        .rty_cnt   (rty_cnt)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state        <= IDLE;
            cmd_ready_o  <= 1'b1;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_sel_o     <= '0;
            wb_dat_o     <= '0;
            bte_q        <= '0;
            len_q        <= '0;
            rdat_valid_o <= 1'b0;
            rdat_o       <= '0;
            rdat_last_o  <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            rdat_valid_o <= 1'b0;
            rdat_last_o  <= 1'b0;
            done_o       <= 1'b0;
            case (state)
                IDLE: if (cmd_valid_i) begin
                    cmd_ready_o <= 1'b0;
                    wb_we_o     <= cmd_we_i;
                    wb_sel_o    <= cmd_sel_i;
                    bte_q       <= cmd_bte_i;
                    len_q       <= cmd_len_i;
                    err_o       <= bad_len;
                    done_o      <= bad_len;
                    state       <= bad_len ? DONE : cmd_we_i ? LOAD : BUS;
                    wb_cyc_o    <= !bad_len && (BURST_EN || !cmd_we_i);
                    wb_stb_o    <= !bad_len && !cmd_we_i;
                end
                LOAD: if (wdat_valid_i) begin
                    wb_dat_o <= wdat_i;
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    state    <= BUS;
                end
                BUS: begin
                    if (ack_ok && !wb_we_o) begin
                        rdat_valid_o <= 1'b1;
                        rdat_o       <= wb_dat_i;
                        rdat_last_o  <= last;
                    end
                    if (wb_err_i || (ack_ok && last) || (rty_ok && rty_cnt == RW'(RETRY_MAX))) begin
                        state    <= DONE;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        done_o   <= 1'b1;
                        err_o    <= !ack_ok;
                    end else if (rty_ok || (ack_ok && !BURST_EN && !wb_we_o)) begin
                        // RETRY doubles as the idle gap between classic read beats
                        state    <= RETRY;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                    end else if (ack_ok) begin
                        if (BURST_EN && wdat_valid_i) begin
                            wb_dat_o <= wdat_i;
                        end else begin
                            state    <= LOAD;
                            wb_cyc_o <= BURST_EN;
                            wb_stb_o <= 1'b0;
                        end
                    end
                end
                RETRY: begin
                    state    <= BUS;
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                end
                DONE: begin
                    state       <= IDLE;
                    cmd_ready_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_peripheral_burst_master_wb.sv
// tb_peripheral_burst_master_wb: directed checks of the burst master against a zero-wait memory slave.
module tb_peripheral_burst_master_wb;
    import peripheral_wb_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_we = 1'b0, cmd_ready;
    logic [31:0] cmd_adr = '0;
    logic [4:0]  cmd_len = '0;
    logic [1:0]  cmd_bte = '0;
    logic [3:0]  cmd_sel = 4'hF;
    logic        wdat_valid, wdat_ready, rdat_valid, rdat_last, done, err;
    logic [31:0] wdat, rdat;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel;
    logic [1:0]  wb_bte;
    logic [2:0]  wb_cti;
    logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err, wb_rty, req, in_gap;

    int vecs = 0, miss = 0;
    int ack_total = 0, rty_total = 0, rd_total = 0, gap_total = 0, cyc_total = 0, widx = 0, gcnt = 0;
    int ack_base = 0, rty_base = 0, rd_base = 0, gap_base = 0, cyc_base = 0, wbase = 0, gbase = 0;
    int err_beat = -1, rty_n = 0, wn = 0, gap_at = -1, gap_len = 0;
    bit inited = 1'b0;
    logic [31:0] mem [256];
    logic [31:0] wq [16];
    logic [31:0] log_adr [256];
    logic [2:0]  log_cti [256];
    logic [31:0] log_rd [256];
    logic [31:0] rty_adr = '0;

    logic [31:0] wrap_a [4] = '{32'h38, 32'h3C, 32'h30, 32'h34};
    logic [31:0] lin_a  [4] = '{32'h38, 32'h3C, 32'h40, 32'h44};
    logic [31:0] wrap_r [4] = '{32'h3, 32'h4, 32'h1, 32'h2};
    logic [31:0] lin_r  [4] = '{32'h6C, 32'h6D, 32'h1, 32'h2};
    logic [31:0] gap_d  [3] = '{32'h11, 32'h22, 32'h33};

    always #5 clk = ~clk;

    peripheral_burst_master_wb dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len), .cmd_bte_i(cmd_bte), .cmd_sel_i(cmd_sel),
        .wdat_valid_i(wdat_valid), .wdat_ready_o(wdat_ready), .wdat_i(wdat),
        .rdat_valid_o(rdat_valid), .rdat_o(rdat), .rdat_last_o(rdat_last),
        .done_o(done), .err_o(err),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
        .wb_bte_o(wb_bte), .wb_cti_o(wb_cti), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty)
    );

    always_comb begin
        req        = wb_cyc && wb_stb;
        wb_err     = req && (ack_total - ack_base) == err_beat;
        wb_rty     = req && !wb_err && (rty_total - rty_base) < rty_n;
        wb_ack     = req && !wb_err && !wb_rty;
        wb_dat_i   = mem[wb_adr[9:2]];
        in_gap     = (widx - wbase) == gap_at && (gcnt - gbase) < gap_len;
        wdat_valid = (widx - wbase) < wn && !in_gap;
        wdat       = wq[4'(widx - wbase)];
    end

    // Memory slave plus bus monitor; everything here is observed at the active edge.
    always @(posedge clk) begin
        if (!inited) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'(i + 'h60);
            inited <= 1'b1;
        end else if (wb_ack && wb_we) begin
            mem[wb_adr[9:2]] <= wb_dat_o;
        end
        if (wb_ack) begin
            log_adr[8'(ack_total)] <= wb_adr;
            log_cti[8'(ack_total)] <= wb_cti;
            ack_total <= ack_total + 1;
        end
        if (wb_rty) begin
            rty_total <= rty_total + 1;
            rty_adr   <= wb_adr;
        end
        if (rdat_valid) begin
            log_rd[8'(rd_total)] <= rdat;
            rd_total <= rd_total + 1;
        end
        if (wb_cyc && !wb_stb) gap_total <= gap_total + 1;
        if (wb_cyc) cyc_total <= cyc_total + 1;
        if (wdat_valid && wdat_ready) widx <= widx + 1;
        if (in_gap) gcnt <= gcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [4:0] len, input logic [1:0] bte);
        @(negedge clk);
        ack_base = ack_total; rty_base = rty_total; rd_base = rd_total;
        gap_base = gap_total; cyc_base = cyc_total; wbase = widx; gbase = gcnt;
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_bte = bte;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int n, output logic e);
        n = 0;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " cyc low at done"}, 32'(wb_cyc), 32'd0);
        e = err;
    endtask

    task automatic settle();
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        logic e;
        #12;
        chk("reset ready", 32'(cmd_ready), 32'd1);
        chk("reset outs", 32'({wb_cyc, wb_stb, wb_cti, wb_bte, wb_we, done, err, wdat_ready, rdat_valid, rdat_last}), 32'd0);
        chk("reset adr", wb_adr, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // incrementing read from preloaded memory
        issue(1'b0, 32'h100, 5'd4, 2'b00);
        wait_done("rd", n, e);
        chk("rd latency", 32'(n), BURST_EN ? 32'd4 : 32'd7);
        chk("rd err", 32'(e), 32'd0);
        chk("rd last with done", 32'({rdat_valid, rdat_last}), 32'd3);
        settle();
        chk("rd beats", 32'(rd_total - rd_base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("rd adr", log_adr[8'(ack_base + i)], 32'h100 + 32'(4 * i));
            chk("rd cti", 32'(log_cti[8'(ack_base + i)]), BURST_EN ? (i == 3 ? 32'd7 : 32'd2) : 32'd0);
            chk("rd data", log_rd[8'(rd_base + i)], 32'hA0 + 32'(i));
        end

        // wrap4 write then linear readback
        for (int i = 0; i < 4; i++) wq[i] = 32'(i + 1);
        wn = 4;
        issue(1'b1, 32'h38, 5'd4, 2'b01);
        wait_done("wr4", n, e);
        chk("wr4 latency", 32'(n), BURST_EN ? 32'd5 : 32'd8);
        chk("wr4 err", 32'(e), 32'd0);
        settle();
        for (int i = 0; i < 4; i++)
            chk("wr4 adr", log_adr[8'(ack_base + i)], BURST_EN ? wrap_a[i] : lin_a[i]);
        wn = 0;
        issue(1'b0, 32'h30, 5'd4, 2'b00);
        wait_done("rb", n, e);
        settle();
        for (int i = 0; i < 4; i++)
            chk("rb data", log_rd[8'(rd_base + i)], BURST_EN ? wrap_r[i] : lin_r[i]);

        // write with a two-cycle data gap after the first beat
        for (int i = 0; i < 3; i++) wq[i] = gap_d[i];
        wn = 3; gap_at = 1; gap_len = 2;
        issue(1'b1, 32'h80, 5'd3, 2'b00);
        wait_done("gap", n, e);
        chk("gap latency", 32'(n), BURST_EN ? 32'd6 : 32'd7);
        settle();
        chk("gap stb low cyc high", 32'(gap_total - gap_base), BURST_EN ? 32'd3 : 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("gap cti", 32'(log_cti[8'(ack_base + i)]), BURST_EN ? (i == 2 ? 32'd7 : 32'd2) : 32'd0);
            chk("gap mem", mem[8'(32 + i)], gap_d[i]);
        end
        wn = 0; gap_at = -1;

        // slave error on the third beat
        err_beat = 2;
        issue(1'b0, 32'h100, 5'd4, 2'b00);
        wait_done("buserr", n, e);
        chk("buserr err", 32'(e), 32'd1);
        settle();
        chk("buserr rdat pulses", 32'(rd_total - rd_base), 32'd2);
        err_beat = -1;

        // illegal lengths never reach the bus
        issue(1'b0, 32'h10, 5'd0, 2'b00);
        wait_done("len0", n, e);
        chk("len0 latency", 32'(n), 32'd0);
        chk("len0 err", 32'(e), 32'd1);
        settle();
        chk("len0 no cyc", 32'(cyc_total - cyc_base), 32'd0);
        issue(1'b1, 32'h10, 5'd17, 2'b00);
        wait_done("len17", n, e);
        chk("len17 latency", 32'(n), 32'd0);
        chk("len17 err", 32'(e), 32'd1);
        settle();
        chk("len17 no cyc", 32'(cyc_total - cyc_base), 32'd0);

        // three retries are tolerated, the fourth errors
        rty_n = 3;
        issue(1'b0, 32'h20, 5'd1, 2'b00);
        wait_done("rty3", n, e);
        chk("rty3 latency", 32'(n), 32'd7);
        chk("rty3 err", 32'(e), 32'd0);
        settle();
        chk("rty3 count", 32'(rty_total - rty_base), 32'd3);
        chk("rty3 rty adr", rty_adr, 32'h20);
        chk("rty3 ack adr", log_adr[8'(ack_base)], 32'h20);
        chk("rty3 data", log_rd[8'(rd_base)], 32'h68);
        rty_n = 4;
        issue(1'b0, 32'h24, 5'd2, 2'b00);
        wait_done("rty4", n, e);
        chk("rty4 err", 32'(e), 32'd1);
        settle();
        chk("rty4 count", 32'(rty_total - rty_base), 32'd4);
        chk("rty4 no ack", 32'(ack_total - ack_base), 32'd0);
        rty_n = 0;

        // asynchronous reset in the middle of a burst
        issue(1'b0, 32'h100, 5'd8, 2'b00);
        chk("pre-reset cyc", 32'(wb_cyc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid reset bus", 32'({wb_cyc, wb_stb, wb_cti}), 32'd0);
        chk("mid reset ready", 32'(cmd_ready), 32'd1);
        chk("mid reset adr", wb_adr, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        issue(1'b0, 32'h104, 5'd1, 2'b00);
        wait_done("post reset", n, e);
        settle();
        chk("post reset data", log_rd[8'(rd_base)], 32'hA1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
